pc_redirect_unit: RTL and testbench

Fetch-side consumer of the execute-stage branch decision. It owns the architectural PC, issues instruction-fetch requests over a valid/ready handshake, and applies taken branches and jumps as PC redirects. On a redirect it flushes the IF and ID stages and raises a trap on a misaligned target. It sits between the controller/branch logic and instruction memory.

---
 rtl/pc_redirect_unit_pkg.sv | 30 +++
 rtl/pc_redirect_unit_if.sv | 26 ++
 rtl/pc_redirect_unit_pc_next_sel.sv | 27 ++
 rtl/pc_redirect_unit.sv | 147 ++++++++++++++
 tb/tb_pc_redirect_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the fetch-side PC redirect unit: FSM encoding,
// next-PC select codes, reset PC default and opcodes shared with the controller.
package pc_redirect_unit_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    ST_BOOT       = 2'd0,
    ST_RUN        = 2'd1,
    ST_HOLD_REDIR = 2'd2,
    ST_HALT       = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PC_SEL_HOLD    = 2'd0,
    PC_SEL_INC     = 2'd1,
    PC_SEL_TARGET  = 2'd2,
    PC_SEL_PENDING = 2'd3
  } pc_sel_e;

  function automatic logic is_misaligned(input logic [1:0] lsbs);
    return lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_redirect_unit_if.sv
// Instruction-fetch request bus between the PC redirect unit (master)
// and instruction memory (slave).
interface pc_redirect_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic            imem_ready;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;

  modport master (
    output imem_req,
    output PC,
    output PCPlus4,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  PC,
    input  PCPlus4,
    output imem_ready
  );

endinterface

// File: rtl/pc_redirect_unit_pc_next_sel.sv
// Combinational next-PC mux: hold, sequential +4, execute target or the
// target parked while an outstanding fetch completes.
module pc_redirect_unit_pc_next_sel
  import pc_redirect_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  pc_sel_e         i_sel,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc_plus4,
  input  logic [XLEN-1:0] i_target,
  input  logic [XLEN-1:0] i_pending,
  output logic [XLEN-1:0] o_next_pc
);

  always_comb begin
    o_next_pc = i_pc;
    unique case (i_sel)
      PC_SEL_HOLD:    o_next_pc = i_pc;
      PC_SEL_INC:     o_next_pc = i_pc_plus4;
      PC_SEL_TARGET:  o_next_pc = i_target;
      PC_SEL_PENDING: o_next_pc = i_pending;
      default:        o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Owns the architectural PC, issues fetch requests and applies execute-stage
// redirects, flushing IF/ID and trapping on misaligned targets.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_i,
  input  logic                ex_valid,
  input  logic                ex_branch,
  input  logic                ex_jump,
  input  logic [XLEN-1:0]     ex_target,
  pc_redirect_unit_if.master  imem,
  output logic                flush_if,
  output logic                flush_id,
  output logic                trap_misaligned,
  output logic                halted,
  output state_e              o_dbg_state
);

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending_target;
  logic            r_req_pending;
  logic            r_flush_if;
  logic            r_flush_id;
  logic            r_trap;
  logic            r_halted;

  logic            w_taken;
  logic            w_misaligned;
  logic            w_req;
  logic            w_fire;
  logic            w_req_outstanding;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  pc_sel_e         w_pc_sel;

  assign w_taken           = ex_valid & (ex_branch | ex_jump);
  assign w_misaligned      = is_misaligned(ex_target[1:0]);
  assign w_pc_plus4        = r_pc + XLEN'(4);

  // Valid/ready: a request transfers on a cycle where imem_req and imem_ready
  // are both high. Once raised, imem_req and PC hold until that transfer;
  // r_req_pending keeps a stalled request alive and HOLD_REDIR keeps one
  // alive across a redirect.
  assign w_req             = ((r_state == ST_RUN) & (~stall_i | r_req_pending))
                           | (r_state == ST_HOLD_REDIR);
  assign w_fire            = w_req & imem.imem_ready;
  assign w_req_outstanding = w_req & ~imem.imem_ready;

  always_comb begin
    w_pc_sel = PC_SEL_HOLD;
    unique case (r_state)
      ST_RUN: begin
        if (w_taken) begin
          if (!w_misaligned && !w_req_outstanding) w_pc_sel = PC_SEL_TARGET;
        end else if (w_fire) begin
          w_pc_sel = PC_SEL_INC;
        end
      end
      ST_HOLD_REDIR: begin
        // A redirect arriving on the completing cycle beats the parked target.
        if (w_fire && !(w_taken && w_misaligned)) begin
          w_pc_sel = w_taken ? PC_SEL_TARGET : PC_SEL_PENDING;
        end
      end
      default: w_pc_sel = PC_SEL_HOLD;
    endcase
  end

  pc_redirect_unit_pc_next_sel #(
    .XLEN (XLEN)
  ) u_pc_next_sel (
    .i_sel      (w_pc_sel),
    .i_pc       (r_pc),
    .i_pc_plus4 (w_pc_plus4),
    .i_target   (ex_target),
    .i_pending  (r_pending_target),
    .o_next_pc  (w_pc_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_BOOT;
      r_pc             <= RESET_PC;
      r_pending_target <= '0;
      r_req_pending    <= 1'b0;
      r_flush_if       <= 1'b0;
      r_flush_id       <= 1'b0;
      r_trap           <= 1'b0;
      r_halted         <= 1'b0;
    end else begin
      r_pc          <= w_pc_next;
      r_req_pending <= w_req_outstanding;
      r_flush_if    <= 1'b0;
      r_flush_id    <= 1'b0;
      r_trap        <= 1'b0;
      unique case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_taken && w_misaligned) begin
            r_state  <= ST_HALT;
            r_trap   <= 1'b1;
            r_halted <= 1'b1;
          end else if (w_taken) begin
            r_flush_if <= 1'b1;
            r_flush_id <= 1'b1;
            if (w_req_outstanding) begin
              r_pending_target <= ex_target;
              r_state          <= ST_HOLD_REDIR;
            end
          end
        end
        ST_HOLD_REDIR: begin
          if (w_taken && w_misaligned) begin
            r_state  <= ST_HALT;
            r_trap   <= 1'b1;
            r_halted <= 1'b1;
          end else begin
            // Also covers the first RUN cycle, discarding the stale fetch.
            r_flush_if <= 1'b1;
            if (w_taken) begin
              r_flush_id       <= 1'b1;
              r_pending_target <= ex_target;
            end
            if (w_fire) r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign imem.imem_req   = w_req;
  assign imem.PC         = r_pc;
  assign imem.PCPlus4    = w_pc_plus4;
  assign flush_if        = r_flush_if;
  assign flush_id        = r_flush_id;
  assign trap_misaligned = r_trap;
  assign halted          = r_halted;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Bench for pc_redirect_unit: directed vector table, hand sequences for
// async reset, then randomized traffic against a behavioural model.
module tb_pc_redirect_unit;
  import pc_redirect_unit_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            stall_i = 1'b0;
  logic            ex_valid = 1'b0;
  logic            ex_branch = 1'b0;
  logic            ex_jump = 1'b0;
  logic [XLEN-1:0] ex_target = '0;
  logic            flush_if;
  logic            flush_id;
  logic            trap_misaligned;
  logic            halted;
  state_e          dbg_state;

  pc_redirect_unit_if #(.XLEN(XLEN)) imem ();

  pc_redirect_unit #(
    .XLEN     (XLEN),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .ex_valid        (ex_valid),
    .ex_branch       (ex_branch),
    .ex_jump         (ex_jump),
    .ex_target       (ex_target),
    .imem            (imem),
    .flush_if        (flush_if),
    .flush_id        (flush_id),
    .trap_misaligned (trap_misaligned),
    .halted          (halted),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic chk_word(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic            m_boot, m_halt, m_wait, m_out, m_fif, m_fid, m_trap;
  logic [XLEN-1:0] m_pc, m_pend;
  logic [XLEN-1:0] exp_q[$];

  task automatic model_reset();
    m_boot = 1'b1; m_halt = 1'b0; m_wait = 1'b0; m_out = 1'b0;
    m_fif = 1'b0;  m_fid = 1'b0;  m_trap = 1'b0;
    m_pc = '0;     m_pend = '0;
    exp_q.delete();
  endtask

  function automatic logic model_req();
    return !m_boot && !m_halt && (m_wait || m_out || !stall_i);
  endfunction

  task automatic model_step(input logic req);
    logic taken, mis, fire;
    taken = ex_valid & (ex_branch | ex_jump);
    mis   = (ex_target[1:0] != 2'b00);
    fire  = req & imem.imem_ready;
    m_fif = 1'b0; m_fid = 1'b0; m_trap = 1'b0;
    if (!m_halt) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (taken && mis) begin
        m_halt = 1'b1; m_trap = 1'b1; m_wait = 1'b0;
      end else if (m_wait) begin
        m_fif = 1'b1;
        if (taken) begin m_fid = 1'b1; m_pend = ex_target; end
        if (fire) begin m_pc = m_pend; m_wait = 1'b0; end
      end else if (taken) begin
        m_fif = 1'b1; m_fid = 1'b1;
        if (req && !imem.imem_ready) begin m_wait = 1'b1; m_pend = ex_target; end
        else m_pc = ex_target;
      end else if (fire) begin
        m_pc = m_pc + 32'd4;
      end
    end
    m_out = req & ~imem.imem_ready;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic v, input logic b, input logic j,
                       input logic [XLEN-1:0] t, input logic r);
    stall_i = s; ex_valid = v; ex_branch = b; ex_jump = j; ex_target = t;
    imem.imem_ready = r;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic            stall, vld, br, jmp, rdy;
    logic [XLEN-1:0] tgt;
    logic            exp_req;
    logic [XLEN-1:0] exp_pc;
    logic            exp_fif, exp_fid, exp_trap, exp_halt;
    state_e          exp_st;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic s, input logic v, input logic b, input logic j,
                         input logic [XLEN-1:0] t, input logic r,
                         input logic er, input logic [XLEN-1:0] ep,
                         input logic fi, input logic fd, input logic tr, input logic hl,
                         input state_e st);
    vec_t x;
    x.stall = s; x.vld = v; x.br = b; x.jmp = j; x.tgt = t; x.rdy = r;
    x.exp_req = er; x.exp_pc = ep; x.exp_fif = fi; x.exp_fid = fd;
    x.exp_trap = tr; x.exp_halt = hl; x.exp_st = st;
    vecs.push_back(x);
  endtask

  initial begin
    logic [XLEN-1:0] got;
    logic            e_req;
    int              halt_cycles;
    imem.imem_ready = 1'b0;

    //      stall vld br jmp target        rdy  req pc            fif fid trp hlt state
    add_vec(0, 0, 0, 0, 32'h0,         1,   0, 32'h0,         0, 0, 0, 0, ST_BOOT);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'h0,         0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'h4,         0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'h8,         0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 1, 0, 32'h500,       1,   1, 32'hC,         0, 0, 0, 0, ST_RUN);
    add_vec(0, 1, 1, 0, 32'h100,       1,   1, 32'h10,        0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'h100,       1, 1, 0, 0, ST_RUN);
    add_vec(0, 1, 0, 1, 32'h20,        1,   1, 32'h104,       0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         0,   1, 32'h20,        1, 1, 0, 0, ST_RUN);
    add_vec(0, 1, 1, 0, 32'h200,       0,   1, 32'h20,        0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         0,   1, 32'h20,        1, 1, 0, 0, ST_HOLD_REDIR);
    add_vec(0, 0, 0, 0, 32'h0,         0,   1, 32'h20,        1, 0, 0, 0, ST_HOLD_REDIR);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'h20,        1, 0, 0, 0, ST_HOLD_REDIR);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'h200,       1, 0, 0, 0, ST_RUN);
    add_vec(1, 0, 0, 0, 32'h0,         1,   0, 32'h204,       0, 0, 0, 0, ST_RUN);
    add_vec(1, 0, 0, 0, 32'h0,         1,   0, 32'h204,       0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         0,   1, 32'h204,       0, 0, 0, 0, ST_RUN);
    add_vec(1, 0, 0, 0, 32'h0,         0,   1, 32'h204,       0, 0, 0, 0, ST_RUN);
    add_vec(1, 0, 0, 0, 32'h0,         1,   1, 32'h204,       0, 0, 0, 0, ST_RUN);
    add_vec(1, 1, 0, 1, 32'hFFFF_FFFC, 1,   0, 32'h208,       0, 0, 0, 0, ST_RUN);
    add_vec(0, 0, 0, 0, 32'h0,         1,   1, 32'hFFFF_FFFC, 1, 1, 0, 0, ST_RUN);
    add_vec(0, 1, 0, 1, 32'h102,       1,   1, 32'h0,         0, 0, 0, 0, ST_RUN);
    add_vec(0, 1, 1, 0, 32'h300,       1,   0, 32'h0,         0, 0, 1, 1, ST_HALT);
    add_vec(0, 1, 0, 1, 32'h400,       1,   0, 32'h0,         0, 0, 0, 1, ST_HALT);
    add_vec(0, 0, 0, 0, 32'h0,         1,   0, 32'h0,         0, 0, 0, 1, ST_HALT);

    do_reset();
    chk_word("reset_pc", imem.PC, 32'h0);
    chk_bit("reset_req", imem.imem_req, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].vld, vecs[i].br, vecs[i].jmp, vecs[i].tgt, vecs[i].rdy);
      #1;
      chk_bit($sformatf("row%0d_req", i), imem.imem_req, vecs[i].exp_req);
      chk_word($sformatf("row%0d_pc", i), imem.PC, vecs[i].exp_pc);
      chk_word($sformatf("row%0d_pc4", i), imem.PCPlus4, vecs[i].exp_pc + 32'd4);
      chk_bit($sformatf("row%0d_flush_if", i), flush_if, vecs[i].exp_fif);
      chk_bit($sformatf("row%0d_flush_id", i), flush_id, vecs[i].exp_fid);
      chk_bit($sformatf("row%0d_trap", i), trap_misaligned, vecs[i].exp_trap);
      chk_bit($sformatf("row%0d_halted", i), halted, vecs[i].exp_halt);
      chk_word($sformatf("row%0d_state", i), 32'(dbg_state), 32'(vecs[i].exp_st));
    end

    // Reset out of HALT, asserted between clock edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_word("halt_reset_pc", imem.PC, 32'h0);
    chk_bit("halt_reset_halted", halted, 1'b0);
    chk_bit("halt_reset_req", imem.imem_req, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Build up a HOLD_REDIR, then hit it with async reset off the edge.
    @(negedge clk);                        // BOOT cycle
    @(negedge clk);                        // RUN, request at PC 0 not accepted
    #1 chk_bit("hold_seq_req", imem.imem_req, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h80, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    #1;
    chk_word("hold_seq_state", 32'(dbg_state), 32'(ST_HOLD_REDIR));
    chk_bit("hold_seq_flush_if", flush_if, 1'b1);
    chk_word("hold_seq_pc", imem.PC, 32'h0);
    #2 reset = 1'b1;
    #1;
    chk_bit("async_req", imem.imem_req, 1'b0);
    chk_word("async_pc", imem.PC, 32'h0);
    chk_word("async_pc4", imem.PCPlus4, 32'h4);
    chk_bit("async_flush_if", flush_if, 1'b0);
    chk_bit("async_flush_id", flush_id, 1'b0);
    chk_bit("async_trap", trap_misaligned, 1'b0);
    chk_bit("async_halted", halted, 1'b0);
    chk_word("async_state", 32'(dbg_state), 32'(ST_BOOT));

    // Randomized traffic against the model.
    do_reset();
    halt_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      if (halt_cycles > 4 || $urandom_range(0, 299) == 0) begin
        chk_word("fetch_drain", 32'(exp_q.size()), 32'h0);
        do_reset();
        halt_cycles = 0;
      end
      @(negedge clk);
      stall_i   = ($urandom_range(0, 3) == 0);
      ex_valid  = ($urandom_range(0, 3) == 0);
      ex_branch = $urandom_range(0, 1) == 1;
      ex_jump   = $urandom_range(0, 1) == 1;
      ex_target = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
      if ($urandom_range(0, 19) == 0) ex_target = 32'hFFFF_FFFC;
      if ($urandom_range(0, 59) == 0) ex_target[1:0] = 2'($urandom_range(1, 3));
      imem.imem_ready = ($urandom_range(0, 2) != 0);
      #1;
      e_req = model_req();
      chk_bit("rnd_req", imem.imem_req, e_req);
      chk_word("rnd_pc", imem.PC, m_pc);
      chk_word("rnd_pc4", imem.PCPlus4, m_pc + 32'd4);
      chk_bit("rnd_flush_if", flush_if, m_fif);
      chk_bit("rnd_flush_id", flush_id, m_fid);
      chk_bit("rnd_trap", trap_misaligned, m_trap);
      chk_bit("rnd_halted", halted, m_halt);
      if (e_req && imem.imem_ready) exp_q.push_back(m_pc);
      if (imem.imem_req && imem.imem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected actual=%h required=none", imem.PC);
        end else begin
          got = exp_q.pop_front();
          chk_word("fetch_addr", imem.PC, got);
        end
      end
      model_step(e_req);
      if (m_halt) halt_cycles++;
    end
    chk_word("fetch_drain_end", 32'(exp_q.size()), 32'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
